// File: rtl/onehot_grant_pkg.sv
// Shared types and helpers for the one-hot grant decoder.
// Holds the FSM state encoding and index decode.
package onehot_grant_pkg;

  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 4;
  localparam int OH_MAX    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Zero result flags an index beyond the requester count.
  function automatic logic [OH_MAX-1:0] idx_to_onehot(
    input logic [3:0] idx,
    input int         n
  );
    logic [OH_MAX-1:0] r;
    r = '0;
    if (int'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_grant_decoder_if.sv
// Beat handshake and grant/ack bundle.
// master drives beats and acks, slave is the decoder.
interface onehot_grant_decoder_if #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_idle;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic             grant_ack;

  modport master (
    output in_valid, in_idx, in_idle, grant_ack,
    input  in_ready, grant, grant_valid
  );

  modport slave (
    input  in_valid, in_idx, in_idle, grant_ack,
    output in_ready, grant, grant_valid
  );

endinterface

// File: rtl/grant_fifo.sv
// Small synchronous FIFO of encoded indices.
// Count is registered so full/empty are glitch-free.
module grant_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr_q];
  assign count   = count_q;

  // Occupancy next-state; simultaneous push/pop cancel.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/onehot_grant_decoder.sv
// Turns queued encoder beats into a held one-hot grant.
// Each grant is followed by one all-zero gap cycle.
module onehot_grant_decoder
  import onehot_grant_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(N),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  onehot_grant_decoder_if.slave  bus,
  output logic                   err,
  output logic [CW-1:0]          count,
  output logic                   busy
);

  state_e           state_q;
  logic [N-1:0]     grant_q;
  logic             gv_q;
  logic             err_q;
  logic             err_d;
  logic             accept;
  logic             in_range;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] rdata;
  logic             full;
  logic             empty;
  logic [N-1:0]     load;

  assign in_range = |idx_to_onehot(4'(bus.in_idx), N);
  assign accept   = bus.in_valid && bus.in_ready;
  assign push     = accept && !bus.in_idle && in_range;
  assign err_d    = accept && !bus.in_idle && !in_range;
  assign pop      = !empty && (state_q != GRANT);
  assign load     = N'(idx_to_onehot(4'(rdata), N));

  assign bus.in_ready    = !full;
  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign err             = err_q;
  assign busy            = !empty || (state_q != IDLE);

  grant_fifo #(
    .W     (IDX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_idx),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // One-cycle pulse for a dropped out-of-range beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  // Grant sequencer: load on pop, hold until ack, then one gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, GAP: begin
          if (!empty) begin
            grant_q <= load;
            gv_q    <= 1'b1;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (bus.grant_ack) begin
            grant_q <= '0;
            gv_q    <= 1'b0;
            state_q <= GAP;
          end
        end
        default: begin
          grant_q <= '0;
          gv_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/onehot_grant_decoder.md
Name: onehot_grant_decoder

Overview:
- Consumer side of the 8-input priority-encoder path. Accepts encoded request beats {idx, idle} through a valid/ready handshake and buffers them in a small FIFO.
- Drives the winning requester's line as a registered one-hot grant, held until that requester acknowledges it.
- Closes the loop requester -> encoder -> this block -> requester.

Parameters:
- N, 8, number of requester lines / one-hot grant width (2..16).
- IDX_W, $clog2(N), width of the encoded index.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  encoded beat present
- in_ready  out  1  block can accept a beat
- in_idx  in  IDX_W  encoded winning index
- in_idle  in  1  encoder reports no request active
- grant  out  N  registered one-hot grant
- grant_valid  out  1  grant holds a live grant
- grant_ack  in  1  requester consumed the grant
- err  out  1  one-cycle pulse: out-of-range index dropped
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  FIFO non-empty or grant/gap phase active

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, sync-free release): grant=0, grant_valid=0, err=0, count=0, FIFO pointers=0, FSM=IDLE, busy=0. in_ready=1 while in reset.
- Handshake: a beat is accepted on an edge where in_valid && in_ready. in_ready = (count != DEPTH), purely from registered count. No push-through when full, even if a pop occurs on the same edge.
- Accepted beat handling:
  - in_idle=1: dropped, no FIFO write, no err.
  - in_idle=0 and in_idx >= N (only possible when N is not a power of 2): dropped, err=1 for the following cycle.
  - Otherwise: in_idx written to the FIFO.
- Push and pop on the same edge leave count unchanged. Pop only when count != 0.
- FSM states IDLE, GRANT, GAP.
  - IDLE: if count != 0, pop on the next edge, load grant = 1<<idx, grant_valid=1, go GRANT.
  - GRANT: grant held stable. On an edge with grant_ack=1: grant=0, grant_valid=0, go GAP. grant_ack is ignored outside GRANT.
  - GAP: exactly one cycle with grant=0. Then, if count != 0, pop and go GRANT; else go IDLE.
- Latency: beat accepted at edge k into an empty, IDLE block gives grant_valid=1 after edge k+1. Back-to-back grants with immediate ack alternate 1 cycle high, 1 cycle zero.
- Ordering: strict FIFO order; no reprioritisation of queued indices.
- Invariants:
  - popcount(grant) is 0 or 1.
  - grant_valid == (grant != 0).
  - grant never changes while in GRANT.
- busy = (count != 0) || (state != IDLE).
- Reset mid-operation: a live grant clears immediately on rst_n falling; queued beats are discarded.

Decomposition:
- Shared package onehot_grant_pkg:
  - state enum (IDLE, GRANT, GAP)
  - default N/DEPTH constants
  - function idx_to_onehot(idx), returning N-bit one-hot or zero if idx >= N
- One sub-module: grant_fifo (parameterised sync FIFO).
  - Inputs: push, pop, wdata.
  - Outputs: rdata, count, full, empty.
  - Async active-low reset.
- FSM and one-hot register live in the top.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> grant=0, grant_valid=0, err=0, count=0, in_ready=1, busy=0.
- Single beat: idx=5, idle=0 accepted at edge k -> grant=8'b0010_0000 and grant_valid=1 after k+1. grant_ack=1 at k+3 -> grant=0 after k+3, GAP, IDLE, busy=0.
- Idle beat: in_idle=1, idx=3 accepted -> count stays 0, grant stays 0, err stays 0.
- Backpressure and order: grant_ack=0, drive beats idx 0..5 -> 5 accepted (1 granted, 4 queued), count=4, in_ready=0, idx 5 stalled. Ack every cycle -> grants 0x01,0x02,0x04,0x08,0x10,0x20 in order, each followed by one zero cycle.
- Out of range (N=6): idx=7, idle=0 accepted -> err=1 for exactly one cycle, no FIFO write, grant unchanged.
- Reset mid-grant: grant=8'h08 with 2 beats queued, rst_n falls -> grant=0 immediately. After release count=0, no further grants without new beats.
